// File: rtl/volume_ctrl.sv
// Push-button volume controller: single step on press, auto-repeat while held,
// saturating level register and a toggling mute with a registered output path.
module volume_ctrl #(
  parameter int WIDTH         = 4,
  parameter int MAX_LEVEL     = 15,
  parameter int INIT_LEVEL    = 8,
  parameter int HOLD_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             up,
  input  logic             down,
  input  logic             mute,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] out_level,
  output logic             muted,
  output logic             step,
  output logic             at_limit,
  output logic [2:0]       dbg_state_o
);

  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0]    HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]    REPEAT_LAST = CW'(REPEAT_CYCLES - 1);
  localparam logic [WIDTH-1:0] MAX_LVL     = WIDTH'(MAX_LEVEL);
  localparam logic [WIDTH-1:0] INIT_LVL    = WIDTH'(INIT_LEVEL);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_FIRST        = 3'd1,
    S_HOLD         = 3'd2,
    S_REPEAT       = 3'd3,
    S_WAIT_RELEASE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             dir_up_q, dir_up_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] level_q, level_d;
  logic             step_q, step_d;
  logic             muted_q, muted_d;
  logic             mute_smp_q, mute_prev_q;

  logic             latched_btn;
  logic             opposite_btn;
  logic             do_step;

  assign latched_btn  = dir_up_q ? up   : down;
  assign opposite_btn = dir_up_q ? down : up;

  // Sequencer: decides when a step is applied; the level update below acts on do_step.
  always_comb begin
    state_d  = state_q;
    dir_up_d = dir_up_q;
    cnt_d    = cnt_q;
    do_step  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (up ^ down) begin
          dir_up_d = up;
          state_d  = S_FIRST;
        end
      end
      S_FIRST: begin
        do_step = 1'b1;
        cnt_d   = '0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!latched_btn) begin
          state_d = S_IDLE;
        end else if (opposite_btn) begin
          state_d = S_WAIT_RELEASE;
        end else if (cnt_q == HOLD_LAST) begin
          do_step = 1'b1;
          cnt_d   = '0;
          state_d = S_REPEAT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_REPEAT: begin
        if (!latched_btn) begin
          state_d = S_IDLE;
        end else if (opposite_btn) begin
          state_d = S_WAIT_RELEASE;
        end else if (cnt_q == REPEAT_LAST) begin
          do_step = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_RELEASE: begin
        if (!up && !down) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Saturating level update; a step that cannot move the level raises no pulse.
  always_comb begin
    level_d = level_q;
    step_d  = 1'b0;
    if (do_step) begin
      if (dir_up_q) begin
        if (level_q < MAX_LVL) begin
          level_d = level_q + WIDTH'(1);
          step_d  = 1'b1;
        end
      end else begin
        if (level_q != '0) begin
          level_d = level_q - WIDTH'(1);
          step_d  = 1'b1;
        end
      end
    end
  end

  // Edge detect on registered mute samples so the toggle lands one edge after the press.
  always_comb begin
    muted_d = muted_q ^ (mute_smp_q & ~mute_prev_q);
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q     <= S_IDLE;
      dir_up_q    <= 1'b0;
      cnt_q       <= '0;
      level_q     <= INIT_LVL;
      step_q      <= 1'b0;
      muted_q     <= 1'b0;
      mute_smp_q  <= 1'b0;
      mute_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_up_q    <= dir_up_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      step_q      <= step_d;
      muted_q     <= muted_d;
      mute_smp_q  <= mute;
      mute_prev_q <= mute_smp_q;
    end
  end

  assign level       = level_q;
  assign out_level   = muted_q ? '0 : level_q;
  assign muted       = muted_q;
  assign step        = step_q;
  assign at_limit    = (level_q == '0) || (level_q == MAX_LVL);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_volume_ctrl.sv
// Directed bench for volume_ctrl: a per-cycle vector table for single presses and
// mute, then hand-written sequences for auto-repeat, saturation, conflicts and reset.
module tb_volume_ctrl;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       up;
  logic       down;
  logic       mute;
  logic [3:0] level;
  logic [3:0] out_level;
  logic       muted;
  logic       step;
  logic       at_limit;
  logic [2:0] dbg_state;

  int n_total = 0;
  int n_pass  = 0;
  int steps_seen;
  logic [31:0] exp_q[$];

  volume_ctrl dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .up         (up),
    .down       (down),
    .mute       (mute),
    .level      (level),
    .out_level  (out_level),
    .muted      (muted),
    .step       (step),
    .at_limit   (at_limit),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       nr;
    logic       u;
    logic       d;
    logic       m;
    logic [3:0] lvl;
    logic [3:0] outl;
    logic       mt;
    logic       st;
    logic       lim;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(logic nr, logic u, logic d, logic m,
                              logic [3:0] lvl, logic [3:0] outl,
                              logic mt, logic st, logic lim);
    vec_t v;
    v.nr = nr; v.u = u; v.d = d; v.m = m;
    v.lvl = lvl; v.outl = outl; v.mt = mt; v.st = st; v.lim = lim;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Drive one cycle of inputs, let the rising edge sample them, settle, count step pulses.
  task automatic tick(input logic nr, input logic u, input logic d, input logic m);
    n_reset = nr; up = u; down = d; mute = m;
    @(posedge clk);
    #1;
    if (step === 1'b1) steps_seen++;
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    steps_seen = 0;
  endtask

  task automatic press(input logic u, input logic d);
    tick(1'b1, u, d, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_reset = 1'b0; up = 1'b0; down = 1'b0; mute = 1'b0;
    steps_seen = 0;

    // nr u d m | level out muted step at_limit (values after the edge)
    vecs[0]  = mk(0, 0, 0, 0,  8,  8, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0,  8,  8, 0, 0, 0);
    vecs[2]  = mk(1, 0, 0, 0,  8,  8, 0, 0, 0);
    vecs[3]  = mk(1, 1, 0, 0,  8,  8, 0, 0, 0);
    vecs[4]  = mk(1, 0, 0, 0,  9,  9, 0, 1, 0);
    vecs[5]  = mk(1, 0, 0, 0,  9,  9, 0, 0, 0);
    vecs[6]  = mk(1, 0, 0, 0,  9,  9, 0, 0, 0);
    vecs[7]  = mk(1, 1, 1, 0,  9,  9, 0, 0, 0);
    vecs[8]  = mk(1, 1, 1, 0,  9,  9, 0, 0, 0);
    vecs[9]  = mk(1, 0, 0, 0,  9,  9, 0, 0, 0);
    vecs[10] = mk(1, 0, 0, 1,  9,  9, 0, 0, 0);
    vecs[11] = mk(1, 0, 0, 1,  9,  0, 1, 0, 0);
    vecs[12] = mk(1, 0, 0, 1,  9,  0, 1, 0, 0);
    vecs[13] = mk(1, 0, 0, 0,  9,  0, 1, 0, 0);
    vecs[14] = mk(1, 1, 0, 0,  9,  0, 1, 0, 0);
    vecs[15] = mk(1, 0, 0, 0, 10,  0, 1, 1, 0);
    vecs[16] = mk(1, 0, 0, 0, 10,  0, 1, 0, 0);
    vecs[17] = mk(1, 0, 0, 1, 10,  0, 1, 0, 0);
    vecs[18] = mk(1, 0, 0, 0, 10, 10, 0, 0, 0);
    vecs[19] = mk(1, 0, 0, 0, 10, 10, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      tick(vecs[i].nr, vecs[i].u, vecs[i].d, vecs[i].m);
      chk($sformatf("vec%0d.level", i),     32'(level),     32'(vecs[i].lvl));
      chk($sformatf("vec%0d.out_level", i), 32'(out_level), 32'(vecs[i].outl));
      chk($sformatf("vec%0d.muted", i),     32'(muted),     32'(vecs[i].mt));
      chk($sformatf("vec%0d.step", i),      32'(step),      32'(vecs[i].st));
      chk($sformatf("vec%0d.at_limit", i),  32'(at_limit),  32'(vecs[i].lim));
    end

    // Auto-repeat: up held for exactly 20 sampled edges; step pulses seen after edges 1, 9, 13, 17.
    do_reset();
    exp_q = {32'd1, 32'd9, 32'd13, 32'd17};
    for (int i = 0; i < 32; i++) begin
      tick(1'b1, (i < 20), 1'b0, 1'b0);
      if (step === 1'b1) begin
        if (exp_q.size() == 0) chk($sformatf("repeat.extra_step@%0d", i), 32'(i), 32'hFFFF_FFFF);
        else chk("repeat.step_edge", 32'(i), exp_q.pop_front());
      end
    end
    chk("repeat.missing_steps", 32'(exp_q.size()), 32'd0);
    chk("repeat.level", 32'(level), 32'd12);
    chk("repeat.step_count", 32'(steps_seen), 32'd4);

    // Down to 1 by single presses, then hold down 30 cycles: one step to 0, then saturation.
    do_reset();
    for (int i = 0; i < 7; i++) press(1'b0, 1'b1);
    chk("down.level_at_1", 32'(level), 32'd1);
    chk("down.at_limit_at_1", 32'(at_limit), 32'd0);
    steps_seen = 0;
    for (int i = 0; i < 30; i++) tick(1'b1, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("down.level_floor", 32'(level), 32'd0);
    chk("down.at_limit_floor", 32'(at_limit), 32'd1);
    chk("down.step_count", 32'(steps_seen), 32'd1);

    // Up to MAX_LEVEL, then one more press must neither move the level nor pulse step.
    do_reset();
    for (int i = 0; i < 7; i++) press(1'b1, 1'b0);
    chk("up.level_max", 32'(level), 32'd15);
    chk("up.at_limit_max", 32'(at_limit), 32'd1);
    chk("up.step_count", 32'(steps_seen), 32'd7);
    steps_seen = 0;
    press(1'b1, 1'b0);
    chk("up.sat_level", 32'(level), 32'd15);
    chk("up.sat_steps", 32'(steps_seen), 32'd0);

    // Opposite button during HOLD: no more steps until both buttons are released.
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) tick(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("conflict.level", 32'(level), 32'd9);
    chk("conflict.step_count", 32'(steps_seen), 32'd1);
    press(1'b0, 1'b1);
    chk("conflict.after_release", 32'(level), 32'd8);

    // Reset in the middle of REPEAT, with mute set and up still held across the reset.
    do_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst.muted_before", 32'(muted), 32'd1);
    for (int i = 0; i < 15; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst.level_in_repeat", 32'(level), 32'd11);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst.level", 32'(level), 32'd8);
    chk("rst.muted", 32'(muted), 32'd0);
    chk("rst.out_level", 32'(out_level), 32'd8);
    chk("rst.step", 32'(step), 32'd0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst.first_edge_level", 32'(level), 32'd8);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst.new_press_level", 32'(level), 32'd9);
    chk("rst.new_press_step", 32'(step), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
